// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM states, default polynomial, feedback helper.
package lfsr_pkg;

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  // Default polynomial x^5+x^3+1 (maximal length 31), shared with the generator.
  localparam int                    LFSR_WIDTH = 5;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 5'b10100;

  // Fibonacci feedback bit: parity of the tapped state bits.
  function automatic logic lfsr_fb(input logic [31:0] s, input logic [31:0] taps);
    return ^(s & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               clear_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (up_i && (count_q != '1))
      count_d = count_q + width_p'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-seeds from the first width_p beats, then predicts
// each bit, pulses error_o on mismatch and drops lock after a run of misses.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                 width_p         = LFSR_WIDTH,
  parameter logic [width_p-1:0] taps_p          = width_p'(LFSR_TAPS),
  parameter int                 count_width_p   = 8,
  parameter int                 unlock_thresh_p = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  input  logic                     data_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic                     error_o,
  output logic [count_width_p-1:0] err_count_o
);

  localparam int                  SeedCntW   = $clog2(width_p + 1);
  localparam logic [SeedCntW-1:0] SeedLast   = SeedCntW'(width_p - 1);
  localparam logic [3:0]          MissThresh = 4'(unlock_thresh_p);

  lfsr_state_e         state_q;
  logic [width_p-1:0]  s_q;
  logic [SeedCntW-1:0] seed_cnt_q;
  logic [3:0]          miss_cnt_q;
  logic                locked_q;
  logic                error_q;

  logic                pred_b;
  logic [width_p-1:0]  s_seed_d;
  logic [width_p-1:0]  s_pred_d;
  logic [3:0]          miss_inc;
  logic                mismatch;

  // Candidate next states: seeding shifts in received data, tracking shifts
  // in the prediction so a single corrupted bit never poisons the register.
  always_comb begin
    pred_b   = lfsr_fb(32'(s_q), 32'(taps_p));
    s_seed_d = {s_q[width_p-2:0], data_i};
    s_pred_d = {s_q[width_p-2:0], pred_b};
    miss_inc = miss_cnt_q + 4'd1;
    mismatch = valid_i && (state_q == LOCKED) && (data_i != pred_b);
  end

  // Seed/track FSM with registered lock and error outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SEED;
      s_q        <= '0;
      seed_cnt_q <= '0;
      miss_cnt_q <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      error_q <= mismatch;
      if (valid_i) begin
        case (state_q)
          SEED: begin
            s_q <= s_seed_d;
            if (seed_cnt_q == SeedLast) begin
              // All-zero window is the LFSR lockup state; discard and refill.
              seed_cnt_q <= '0;
              if (s_seed_d != '0) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              seed_cnt_q <= seed_cnt_q + SeedCntW'(1);
            end
          end
          LOCKED: begin
            s_q <= s_pred_d;
            if (mismatch) begin
              if (miss_inc == MissThresh) begin
                state_q    <= SEED;
                locked_q   <= 1'b0;
                miss_cnt_q <= '0;
                seed_cnt_q <= '0;
              end else begin
                miss_cnt_q <= miss_inc;
              end
            end else begin
              miss_cnt_q <= '0;
            end
          end
          default: state_q <= SEED;
        endcase
      end
    end
  end

  sat_counter #(
    .width_p (count_width_p)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (mismatch),
    .clear_i (clear_i),
    .count_o (err_count_o)
  );

  assign locked_o = locked_q;
  assign error_o  = error_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a hand-computed vector table plus
// sequences built from a reference generator stream.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       data = 1'b0;
  logic       clr = 1'b0;
  logic       locked, error;
  logic [7:0] cnt;
  logic       locked2, error2;
  logic [1:0] cnt2;

  int total = 0;
  int bad = 0;
  logic [4:0] g;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data), .clear_i(clr),
    .locked_o(locked), .error_o(error), .err_count_o(cnt)
  );

  lfsr_checker #(.count_width_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data), .clear_i(clr),
    .locked_o(locked2), .error_o(error2), .err_count_o(cnt2)
  );

  typedef struct {
    logic v, d, c;
    logic e_lock, e_err;
    int   e_cnt;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic c);
    @(negedge clk);
    valid = v; data = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_count", cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference generator: x^5+x^3+1 Fibonacci LFSR, emits the new bit.
  task automatic gen(output logic b);
    b = ^(g & 5'b10100);
    g = {g[3:0], b};
  endtask

  initial begin
    logic b, d;
    int k;

    // Stream from seed 00001 is 0 0 1 0 1 1 0 0 1 1 1 1 1 0 0 0 1 ...
    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0};  // gap, junk data ignored
    tbl[3]  = '{1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 0};  // 5th seed beat -> locked
    tbl[6]  = '{1, 1, 0, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 1, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 1};  // x8=0 sent as 1
    tbl[9]  = '{1, 1, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 1};
    tbl[11] = '{1, 1, 0, 1, 0, 1};
    tbl[12] = '{1, 1, 1, 1, 0, 0};  // clear on match
    tbl[13] = '{1, 0, 0, 1, 1, 1};  // x12=1 sent as 0
    tbl[14] = '{1, 0, 1, 1, 1, 0};  // mismatch + clear -> 0
    tbl[15] = '{1, 0, 0, 1, 0, 0};  // match resets miss run
    tbl[16] = '{1, 1, 0, 1, 1, 1};
    tbl[17] = '{1, 1, 0, 1, 1, 2};
    tbl[18] = '{1, 0, 0, 0, 1, 3};  // third consecutive miss unlocks
    tbl[19] = '{1, 1, 0, 0, 0, 3};

    repeat (2) @(posedge clk);
    apply_reset();

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_lock);
      chk($sformatf("tbl%0d_error", i), error, tbl[i].e_err);
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].e_cnt);
    end

    // A: clean 100-beat stream
    apply_reset();
    g = 5'b00001;
    for (int n = 1; n <= 100; n++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      chk("A_locked", locked, (n >= 5) ? 1 : 0);
      chk("A_error", error, 0);
    end
    chk("A_count", cnt, 0);

    // B: beat 40 inverted
    apply_reset();
    g = 5'b00001;
    for (int n = 1; n <= 100; n++) begin
      gen(b);
      step(1'b1, (n == 40) ? ~b : b, 1'b0);
      chk("B_locked", locked, (n >= 5) ? 1 : 0);
      chk("B_error", error, (n == 40) ? 1 : 0);
    end
    chk("B_count", cnt, 1);

    // C: three consecutive corrupted beats drop lock, relock 5 beats later
    apply_reset();
    g = 5'b00001;
    for (int n = 1; n <= 60; n++) begin
      gen(b);
      step(1'b1, (n >= 20 && n <= 22) ? ~b : b, 1'b0);
      chk("C_locked", locked, ((n >= 5 && n < 22) || n >= 27) ? 1 : 0);
      chk("C_error", error, (n >= 20 && n <= 22) ? 1 : 0);
    end
    chk("C_count", cnt, 3);

    // D: all-zero seed window is rejected
    apply_reset();
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("D_zero_locked", locked, 0);
      chk("D_zero_error", error, 0);
    end
    g = 5'b00001;
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      chk("D_locked", locked, (n >= 5) ? 1 : 0);
      chk("D_error", error, 0);
    end

    // E: 2-bit counter saturates; clear beats a simultaneous mismatch
    apply_reset();
    g = 5'b00001;
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      d = b;
      if (n >= 10 && n <= 18 && (n % 2 == 0)) begin d = ~b; k++; end
      if (n == 22) d = ~b;
      step(1'b1, d, (n == 22) ? 1'b1 : 1'b0);
      chk("E_locked2", locked2, (n >= 5) ? 1 : 0);
      if (n >= 10 && n <= 21) chk("E_sat_count2", cnt2, (k > 3) ? 3 : k);
      if (n == 22) begin
        chk("E_clr_error2", error2, 1);
        chk("E_clr_count2", cnt2, 0);
        chk("E_clr_count", cnt, 0);
      end
    end
    chk("E_wide_count_pre", k, 5);

    // F: random valid gaps, one injected error, then mid-stream reset
    apply_reset();
    g = 5'b00001;
    k = 0;
    for (int cyc = 0; cyc < 400 && k < 30; cyc++) begin
      logic inj;
      inj = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        gen(b);
        k++;
        inj = (k == 20);
        step(1'b1, inj ? ~b : b, 1'b0);
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("F_locked", locked, (k >= 5) ? 1 : 0);
      chk("F_error", error, inj ? 1 : 0);
    end
    chk("F_beats", k, 30);
    chk("F_count", cnt, 1);
    apply_reset();
    for (int n = 1; n <= 12; n++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      chk("F_reseed_locked", locked, (n >= 5) ? 1 : 0);
      chk("F_reseed_error", error, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
